// File: rtl/keypad_saw_voice.sv
`default_nettype none
// ============================================================================
// Module   : keypad_saw_voice
// Purpose  : Single-voice keypad synthesizer. Scans a 4x4 active-low matrix
//            keypad, latches the decoded key index, looks up a C-major note
//            phase increment, runs a free-running DDS phase accumulator and
//            emits a signed sawtooth sample (silenced when no key is held).
//            The clock is the audio sample clock.
// Ports    : clk_i         sample clock
//            reset_i       synchronous active-high reset
//            kpyd_row_i    keypad rows, active-low, synchronous to clk_i
//            kpyd_col_o    column drive, active-low, one column low at a time
//            hex_o         last decoded key index (row*4 + col)
//            key_active_o  a key was seen during the last complete sweep
//            addr_o        waveform address (accumulator MSBs)
//            data_o        signed sawtooth sample, WIDTH bits
// Revision : 1.0 - initial release
// ============================================================================
module keypad_saw_voice #(
  parameter int WIDTH       = 24,
  parameter int DEPTH_LOG2  = 10,
  parameter int ACC_WIDTH   = 32,
  parameter int SAMPLE_RATE = 48000,
  parameter int SCAN_DIV    = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [3:0]            kpyd_row_i,
  output logic [3:0]            kpyd_col_o,
  output logic [3:0]            hex_o,
  output logic                  key_active_o,
  output logic [DEPTH_LOG2-1:0] addr_o,
  output logic [WIDTH-1:0]      data_o
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Note frequencies in Hz, indexed by key number.
  function automatic int unsigned note_hz(input int unsigned idx);
    case (idx)
      0:       note_hz = 261;
      1:       note_hz = 294;
      2:       note_hz = 330;
      3:       note_hz = 349;
      4:       note_hz = 392;
      5:       note_hz = 440;
      6:       note_hz = 494;
      7:       note_hz = 523;
      8:       note_hz = 587;
      9:       note_hz = 659;
      10:      note_hz = 698;
      11:      note_hz = 784;
      12:      note_hz = 880;
      13:      note_hz = 988;
      14:      note_hz = 1046;
      default: note_hz = 1174;
    endcase
  endfunction

  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            col_sel_q, col_sel_d;
  logic [3:0]            hex_q, hex_d;
  logic                  seen_q, seen_d;
  logic                  active_q, active_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]      data_q, data_d;

  logic                  w_tick;
  logic                  w_sweep_end;
  logic [3:0]            w_row_low;
  logic                  w_any_low;
  logic                  w_one_low;
  logic [1:0]            w_row_idx;
  logic [1:0]            w_col_idx;
  logic [ACC_WIDTH-1:0]  w_inc_rom [16];
  logic [ACC_WIDTH-1:0]  w_phase_inc;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic [DEPTH_LOG2-1:0] w_offset_addr;
  logic [WIDTH-1:0]      w_ramp;

  // Increment ROM: every entry is an elaboration-time constant, so the
  // 64-bit division folds away and only a 16-entry constant table remains.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_inc_rom
      localparam longint unsigned INC =
        (64'(note_hz(gi)) << ACC_WIDTH) / 64'(SAMPLE_RATE);
      assign w_inc_rom[gi] = ACC_WIDTH'(INC);
    end
  endgenerate

  assign w_phase_inc   = w_inc_rom[hex_q];
  assign w_addr        = acc_q[ACC_WIDTH-1 -: DEPTH_LOG2];
  // Inverting the address MSB turns the unsigned ramp into a two's
  // complement ramp centred on zero (addr 0 -> most negative value).
  assign w_offset_addr = {~w_addr[DEPTH_LOG2-1], w_addr[DEPTH_LOG2-2:0]};

  generate
    if (WIDTH > DEPTH_LOG2) begin : g_ramp_pad
      assign w_ramp = {w_offset_addr, {(WIDTH-DEPTH_LOG2){1'b0}}};
    end else begin : g_ramp_trunc
      assign w_ramp = w_offset_addr[DEPTH_LOG2-1 -: WIDTH];
    end
  endgenerate

  // Row / column decode.
  always_comb begin
    w_row_low = ~kpyd_row_i;
    w_any_low = |w_row_low;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    w_one_low = w_any_low && ((w_row_low & (w_row_low - 4'd1)) == 4'd0);

    w_row_idx = 2'd0;
    case (w_row_low)
      4'b0010: w_row_idx = 2'd1;
      4'b0100: w_row_idx = 2'd2;
      4'b1000: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase

    w_col_idx = 2'd0;
    case (col_sel_q)
      4'b0010: w_col_idx = 2'd1;
      4'b0100: w_col_idx = 2'd2;
      4'b1000: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  assign w_tick      = (div_q == DIV_LAST);
  assign w_sweep_end = w_tick && col_sel_q[3];

  // Next-state logic.
  always_comb begin
    div_d     = w_tick ? '0 : div_q + DIV_W'(1);
    col_sel_d = w_tick ? {col_sel_q[2:0], col_sel_q[3]} : col_sel_q;
    hex_d     = w_one_low ? {w_row_idx, w_col_idx} : hex_q;

    active_d  = active_q;
    seen_d    = seen_q | w_any_low;
    if (w_sweep_end) begin
      active_d = seen_q;
      // A press in the sweep-closing cycle opens the next sweep's record.
      seen_d   = w_any_low;
    end

    acc_d  = acc_q + w_phase_inc;
    data_d = active_q ? w_ramp : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q     <= '0;
      col_sel_q <= 4'b0001;
      hex_q     <= 4'd0;
      seen_q    <= 1'b0;
      active_q  <= 1'b0;
      acc_q     <= '0;
      data_q    <= '0;
    end else begin
      div_q     <= div_d;
      col_sel_q <= col_sel_d;
      hex_q     <= hex_d;
      seen_q    <= seen_d;
      active_q  <= active_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
    end
  end

  assign kpyd_col_o   = ~col_sel_q;
  assign hex_o        = hex_q;
  assign key_active_o = active_q;
  assign addr_o       = w_addr;
  assign data_o       = data_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_saw_voice.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_saw_voice
// Purpose  : Self-checking bench for keypad_saw_voice. A keypad model drives
//            the rows from the held key and the live column drive; a
//            behavioural model derives the expected outputs of every cycle
//            from elapsed-cycle arithmetic and the press history, queues
//            them, and a monitor process pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_saw_voice;

  localparam int WIDTH       = 24;
  localparam int DEPTH_LOG2  = 10;
  localparam int ACC_WIDTH   = 32;
  localparam int SAMPLE_RATE = 48000;
  localparam int SCAN_DIV    = 16;
  localparam int SWEEP       = 4 * SCAN_DIV;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic [3:0]            kpyd_row_i;
  logic [3:0]            kpyd_col_o;
  logic [3:0]            hex_o;
  logic                  key_active_o;
  logic [DEPTH_LOG2-1:0] addr_o;
  logic [WIDTH-1:0]      data_o;

  always #5 clk = ~clk;

  keypad_saw_voice #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ACC_WIDTH  (ACC_WIDTH),
    .SAMPLE_RATE(SAMPLE_RATE),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .kpyd_row_i  (kpyd_row_i),
    .kpyd_col_o  (kpyd_col_o),
    .hex_o       (hex_o),
    .key_active_o(key_active_o),
    .addr_o      (addr_o),
    .data_o      (data_o)
  );

  typedef struct {
    logic [3:0]            col;
    logic [3:0]            hex;
    logic                  ka;
    logic [DEPTH_LOG2-1:0] addr;
    logic [WIDTH-1:0]      data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int NOTE_HZ [16] = '{261, 294, 330, 349, 392, 440, 494, 523,
                       587, 659, 698, 784, 880, 988, 1046, 1174};

  // Model state: cycles since reset, per-cycle "any row low" history,
  // last valid decoded key, integrated phase.
  bit                m_valid = 1'b0;
  int                m_n;
  bit                m_any[$];
  int                m_hex;
  longint unsigned   m_acc;
  bit                m_prev_ka;
  int                m_prev_addr;

  bit cnt_en = 1'b0;
  bit prev_msb = 1'b0;
  int fall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned inc_of(input int k);
    return (longint'(NOTE_HZ[k]) << ACC_WIDTH) / longint'(SAMPLE_RATE);
  endfunction

  function automatic int model_col(input int n);
    return (n / SCAN_DIV) % 4;
  endfunction

  // Active during sweep m if any row was low in the 64 cycles ending one
  // cycle before the previous sweep boundary.
  function automatic bit model_ka(input int n);
    int m, lo, hi;
    m = n / SWEEP;
    if (m == 0) return 1'b0;
    lo = SWEEP * m - SWEEP - 1;
    if (lo < 0) lo = 0;
    hi = SWEEP * m - 2;
    for (int s = lo; s <= hi; s++)
      if (m_any[s]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [WIDTH-1:0] ramp_of(input int a);
    int v;
    v = a * (1 << (WIDTH - DEPTH_LOG2)) - (1 << (WIDTH - 1));
    return WIDTH'(v);
  endfunction

  // mode 0: all keys released, 1: hold key, 2: raw row pattern
  task automatic cycle(input bit rst, input int mode, input int key, input logic [3:0] raw);
    exp_t       e;
    logic [3:0] row;
    logic [3:0] cmask;
    int         r;
    @(posedge clk);
    #1;
    if (m_valid) begin
      e.col  = ~(4'b0001 << model_col(m_n));
      e.hex  = 4'(m_hex);
      e.ka   = model_ka(m_n);
      e.addr = DEPTH_LOG2'(m_acc >> (ACC_WIDTH - DEPTH_LOG2));
      e.data = (m_n == 0) ? '0 : (m_prev_ka ? ramp_of(m_prev_addr) : '0);
      m_prev_ka   = e.ka;
      m_prev_addr = int'(e.addr);
      sb_q.push_back(e);
    end
    reset_i = rst;
    row = 4'hF;
    if (mode == 1) begin
      cmask = ~(4'b0001 << (key % 4));
      if (kpyd_col_o == cmask) row = ~(4'b0001 << (key / 4));
    end else if (mode == 2) begin
      row = raw;
    end
    kpyd_row_i = row;
    if (rst) begin
      m_valid = 1'b1;
      m_n     = 0;
      m_any.delete();
      m_hex   = 0;
      m_acc   = 0;
    end else if (m_valid) begin
      m_any.push_back(row != 4'hF);
      m_acc = (m_acc + inc_of(m_hex)) & 64'hFFFF_FFFF;
      if ($countones(~row) == 1) begin
        r = 0;
        for (int i = 0; i < 4; i++) if (!row[i]) r = i;
        m_hex = r * 4 + model_col(m_n);
      end
      m_n++;
    end
  endtask

  task automatic run(input int n, input int mode, input int key, input logic [3:0] raw);
    for (int i = 0; i < n; i++) cycle(1'b0, mode, key, raw);
  endtask

  // Monitor: compare whatever expectation the model has queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("kpyd_col_o",   32'(kpyd_col_o),   32'(e.col));
      chk("hex_o",        32'(hex_o),        32'(e.hex));
      chk("key_active_o", 32'(key_active_o), 32'(e.ka));
      chk("addr_o",       32'(addr_o),       32'(e.addr));
      chk("data_o",       32'(data_o),       32'(e.data));
    end
    if (cnt_en && prev_msb && !addr_o[DEPTH_LOG2-1]) fall_cnt++;
    prev_msb = addr_o[DEPTH_LOG2-1];
  end

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    int len, mode, key;
    reset_i    = 1'b1;
    kpyd_row_i = 4'hF;

    // Reset, then idle through a column step and a full sweep.
    cycle(1'b1, 0, 0, 4'hF);
    cycle(1'b1, 0, 0, 4'hF);
    run(SCAN_DIV + SWEEP, 0, 0, 4'hF);

    // Single press: row 1, column 2 -> key 6.
    run(150, 1, 6, 4'hF);
    @(negedge clk);
    chk("press_hex", 32'(hex_o), 32'd6);
    chk("press_active", 32'(key_active_o), 32'd1);

    // Two rows low together must not change the decoded key.
    run(80, 2, 0, 4'b0110);
    @(negedge clk);
    chk("multirow_hex", 32'(hex_o), 32'd6);

    // Release: activity drops, output silent, key index retained.
    run(200, 0, 0, 4'hF);
    @(negedge clk);
    chk("release_active", 32'(key_active_o), 32'd0);
    chk("release_data", 32'(data_o), 32'd0);
    chk("release_hex", 32'(hex_o), 32'd6);

    // Randomized presses, raw row patterns, releases and mid-run resets.
    for (int total = 0; total < 3000; total += len) begin
      len  = int'($urandom_range(10, 200));
      mode = int'($urandom_range(0, 3));
      key  = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) cycle(1'b1, 0, 0, 4'hF);
      if (mode == 3) run(len, 2, 0, 4'($urandom_range(0, 15)));
      else           run(len, (mode == 0) ? 0 : 1, key, 4'hF);
    end

    // Frequency: key 5 (440 Hz) for one second of samples.
    run(200, 1, 5, 4'hF);
    fall_cnt = 0;
    cnt_en   = 1'b1;
    run(SAMPLE_RATE, 1, 5, 4'hF);
    cnt_en   = 1'b0;
    check_range("freq_440_edges", fall_cnt, 439, 441);

    // Highest note: many accumulator wraps in half a second.
    run(200, 1, 15, 4'hF);
    fall_cnt = 0;
    cnt_en   = 1'b1;
    run(SAMPLE_RATE / 2, 1, 15, 4'hF);
    cnt_en   = 1'b0;
    check_range("freq_1174_edges", fall_cnt, 586, 588);

    run(4, 0, 0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
